uart_loader: RTL and testbench

UART_LOADER -- requirements
Module: uart_loader

---
 rtl/uart_loader.sv | 146 ++++++++++++++
 tb/tb_uart_loader.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_loader.sv
// Serial boot loader: parses load (0x55) and go (0x47) frames from a UART,
// writes payload bytes to memory, and answers with ACK/NAK.
module uart_loader #(
  parameter int TX_GAP         = 2400,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        cpu_clk,
  input  logic        rst_n,
  input  logic        get_recv,
  input  logic [7:0]  recv_out,
  output logic        set_recv_clear,
  output logic [7:0]  send_in,
  output logic        set_send,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        run,
  output logic [15:0] run_addr,
  output logic        busy,
  output logic [7:0]  err_count
);
  localparam int MAXC = (TX_GAP > TIMEOUT_CYCLES) ? TX_GAP : TIMEOUT_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [7:0] ACK       = 8'h06;
  localparam logic [7:0] NAK       = 8'h15;
  localparam logic [7:0] SYNC_LOAD = 8'h55;
  localparam logic [7:0] SYNC_GO   = 8'h47;

  typedef enum logic [3:0] {
    IDLE, L_AHI, L_ALO, L_LEN, L_DATA, L_CHK, G_AHI, G_ALO, RESP
  } state_t;

  state_t        state;
  logic          guard;
  logic [CW-1:0] timer;
  logic [15:0]   addr;
  logic [8:0]    cnt;
  logic [7:0]    sum;
  logic          take;

  // A byte is taken only outside RESP and never while the previous clear
  // pulse or its trailing guard cycle is in flight.
  assign take = get_recv && !set_recv_clear && !guard && (state != RESP);
  assign busy = (state != IDLE);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge cpu_clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      guard          <= 1'b0;
      timer          <= '0;
      addr           <= 16'h0000;
      cnt            <= 9'd0;
      sum            <= 8'h00;
      set_recv_clear <= 1'b0;
      send_in        <= 8'h00;
      set_send       <= 1'b0;
      mem_addr       <= 16'h0000;
      mem_wdata      <= 8'h00;
      mem_we         <= 1'b0;
      run            <= 1'b0;
      run_addr       <= 16'h0000;
      err_count      <= 8'h00;
    end else begin
      set_recv_clear <= take;
      guard          <= set_recv_clear;
      mem_we         <= 1'b0;
      run            <= 1'b0;
      set_send       <= 1'b0;
      if (take) begin
        timer <= '0;
        case (state)
          IDLE: begin
            if (recv_out == SYNC_LOAD) begin
              state <= L_AHI;
              sum   <= 8'h00;
            end else if (recv_out == SYNC_GO) begin
              state <= G_AHI;
            end
          end
          L_AHI: begin
            addr[15:8] <= recv_out;
            sum        <= sum + recv_out;
            state      <= L_ALO;
          end
          L_ALO: begin
            addr[7:0] <= recv_out;
            sum       <= sum + recv_out;
            state     <= L_LEN;
          end
          L_LEN: begin
            cnt   <= (recv_out == 8'h00) ? 9'd256 : {1'b0, recv_out};
            sum   <= sum + recv_out;
            state <= L_DATA;
          end
          L_DATA: begin
            mem_we    <= 1'b1;
            mem_addr  <= addr;
            mem_wdata <= recv_out;
            addr      <= addr + 16'd1;
            sum       <= sum + recv_out;
            cnt       <= cnt - 9'd1;
            if (cnt == 9'd1) state <= L_CHK;
          end
          L_CHK: begin
            send_in <= (sum == recv_out) ? ACK : NAK;
            if (sum != recv_out) err_count <= sat_inc(err_count);
            state   <= RESP;
          end
          G_AHI: begin
            addr[15:8] <= recv_out;
            state      <= G_ALO;
          end
          G_ALO: begin
            run      <= 1'b1;
            run_addr <= {addr[15:8], recv_out};
            send_in  <= ACK;
            state    <= RESP;
          end
          default: ;
        endcase
      end else if (state == RESP) begin
        // set_send fires one cycle into RESP so it can never overlap run/mem_we.
        if (timer == '0) set_send <= 1'b1;
        if (timer == CW'(TX_GAP)) begin
          state <= IDLE;
          timer <= '0;
        end else begin
          timer <= timer + CW'(1);
        end
      end else if (state != IDLE) begin
        if (timer == CW'(TIMEOUT_CYCLES - 1)) begin
          state     <= IDLE;
          timer     <= '0;
          err_count <= sat_inc(err_count);
        end else begin
          timer <= timer + CW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_loader.sv
// Scoreboard bench for uart_loader: a UART model feeds frames, a frame-level
// model predicts writes/responses, and a monitor checks what the DUT emits.
module tb_uart_loader;
  localparam int TX_GAP = 20;
  localparam int TMO    = 200;

  logic        cpu_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        get_recv = 1'b0;
  logic [7:0]  recv_out = 8'h00;
  logic        set_recv_clear, set_send, mem_we, run, busy;
  logic [7:0]  send_in, mem_wdata, err_count;
  logic [15:0] mem_addr, run_addr;

  always #5 cpu_clk = ~cpu_clk;

  uart_loader #(.TX_GAP(TX_GAP), .TIMEOUT_CYCLES(TMO)) dut (
    .cpu_clk(cpu_clk), .rst_n(rst_n), .get_recv(get_recv), .recv_out(recv_out),
    .set_recv_clear(set_recv_clear), .send_in(send_in), .set_send(set_send),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .run(run), .run_addr(run_addr), .busy(busy), .err_count(err_count)
  );

  int checks = 0;
  int passes = 0;
  int model_err = 0;

  logic [7:0]  uq[$];
  logic [7:0]  last_b = 8'h00;
  int          stale_cnt = 0;
  int          gap = 0;
  logic [23:0] exp_wr[$];
  logic [7:0]  exp_send[$];
  logic [15:0] exp_run[$];
  logic [23:0] e_wr;
  logic [7:0]  e_send;
  logic [15:0] e_run;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  task automatic fail_evt(input string name);
    checks++;
    $display("FAIL %s: got an event, want none", name);
  endtask

  // UART model: after a clear the old byte stays visible for two more edges
  // (so the guard cycle is exercised), then a random gap before the next byte.
  initial forever begin
    @(negedge cpu_clk);
    if (!rst_n) begin
      stale_cnt = 0;
      gap = 0;
    end else if (set_recv_clear) begin
      if (stale_cnt == 0 && gap == 0 && uq.size() > 0) begin
        checks++;
        passes++;
        last_b = uq.pop_front();
      end else begin
        fail_evt("recv_clear_extra");
      end
      stale_cnt = 2;
      gap = $urandom_range(0, 3);
    end else if (stale_cnt > 0) begin
      stale_cnt--;
    end else if (gap > 0) begin
      gap--;
    end
    get_recv = rst_n && (stale_cnt > 0 || (gap == 0 && uq.size() > 0));
    recv_out = (stale_cnt > 0) ? last_b : ((uq.size() > 0) ? uq[0] : 8'h00);
  end

  // Monitor: every strobe must match the head of its expectation queue.
  initial forever begin
    @(negedge cpu_clk);
    if (rst_n) begin
      if (int'(mem_we) + int'(run) + int'(set_send) > 1) fail_evt("strobe_overlap");
      if (mem_we) begin
        if (exp_wr.size() == 0) fail_evt("unexpected_mem_we");
        else begin
          e_wr = exp_wr.pop_front();
          chk("mem_write", {8'h00, mem_addr, mem_wdata}, {8'h00, e_wr});
        end
      end
      if (set_send) begin
        if (exp_send.size() == 0) fail_evt("unexpected_set_send");
        else begin
          e_send = exp_send.pop_front();
          chk("send_in", {24'h0, send_in}, {24'h0, e_send});
        end
      end
      if (run) begin
        if (exp_run.size() == 0) fail_evt("unexpected_run");
        else begin
          e_run = exp_run.pop_front();
          chk("run_addr", {16'h0, run_addr}, {16'h0, e_run});
        end
      end
    end
  end

  // Frame model: writes go to addr+i (mod 2^16); checksum is the byte sum of
  // header fields and data; bad!=0 corrupts the checksum and expects a NAK.
  task automatic put_load(input logic [15:0] a, input int n, input logic [7:0] d[$],
                          input logic [7:0] bad);
    logic [7:0] s, len;
    len = n[7:0];
    s = a[15:8] + a[7:0] + len;
    uq.push_back(8'h55);
    uq.push_back(a[15:8]);
    uq.push_back(a[7:0]);
    uq.push_back(len);
    for (int i = 0; i < n; i++) begin
      uq.push_back(d[i]);
      s = s + d[i];
      exp_wr.push_back({a + 16'(i), d[i]});
    end
    uq.push_back(s + bad);
    if (bad == 8'h00) exp_send.push_back(8'h06);
    else begin
      exp_send.push_back(8'h15);
      if (model_err < 255) model_err++;
    end
  endtask

  task automatic put_go(input logic [15:0] a);
    uq.push_back(8'h47);
    uq.push_back(a[15:8]);
    uq.push_back(a[7:0]);
    exp_run.push_back(a);
    exp_send.push_back(8'h06);
  endtask

  task automatic wait_idle(input string name, input int bound);
    int  k;
    bit  idle;
    k = 0;
    idle = 1'b0;
    while (!idle && k < bound) begin
      @(negedge cpu_clk);
      #1;
      k++;
      idle = (uq.size() == 0 && stale_cnt == 0 && !busy);
    end
    chk({name, "_idle"}, {31'h0, idle}, 32'h1);
    repeat (2) @(negedge cpu_clk);
    #1;
    chk({name, "_err_count"}, {24'h0, err_count}, model_err[31:0]);
    chk({name, "_pending"}, exp_wr.size() + exp_send.size() + exp_run.size(), 32'h0);
  endtask

  task automatic check_reset(input string name);
    chk({name, "_strobes"}, {27'h0, set_recv_clear, set_send, mem_we, run, busy}, 32'h0);
    chk({name, "_send_in"}, {24'h0, send_in}, 32'h0);
    chk({name, "_mem"}, {8'h0, mem_addr, mem_wdata}, 32'h0);
    chk({name, "_run_addr"}, {16'h0, run_addr}, 32'h0);
    chk({name, "_err_count"}, {24'h0, err_count}, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  d[$];
    logic [15:0] a;
    logic [7:0]  bad, b;
    int          n, r, k;

    rst_n = 1'b0;
    repeat (3) @(negedge cpu_clk);
    #1;
    check_reset("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge cpu_clk);

    d = '{8'hAA, 8'hBB};
    put_load(16'h1234, 2, d, 8'h00);
    wait_idle("load_ack", 1000);

    d = '{8'h7F};
    put_load(16'h0010, 1, d, 8'h70);
    wait_idle("load_nak", 1000);

    d = '{8'h01, 8'h02};
    put_load(16'hFFFF, 2, d, 8'h00);
    wait_idle("load_wrap", 1000);

    put_go(16'h8000);
    wait_idle("go", 1000);

    uq.push_back(8'h00);
    uq.push_back(8'hA5);
    wait_idle("junk", 1000);

    // Partial frame then silence: must time out without a response.
    uq.push_back(8'h55);
    uq.push_back(8'h12);
    k = 0;
    while (uq.size() != 0 && k < 100) begin
      @(negedge cpu_clk);
      k++;
    end
    repeat (TMO / 2) @(negedge cpu_clk);
    #1;
    chk("timeout_not_early", {31'h0, busy}, 32'h1);
    model_err++;
    wait_idle("timeout", TMO * 2);
    d = '{8'h5A, 8'hC3, 8'h11};
    put_load(16'h4000, 3, d, 8'h00);
    wait_idle("after_timeout", 1000);

    // Reset in the middle of the data phase.
    uq.push_back(8'h55);
    uq.push_back(8'h20);
    uq.push_back(8'h00);
    uq.push_back(8'h05);
    uq.push_back(8'hA1);
    uq.push_back(8'hA2);
    exp_wr.push_back({16'h2000, 8'hA1});
    exp_wr.push_back({16'h2001, 8'hA2});
    k = 0;
    while (exp_wr.size() != 0 && k < 200) begin
      @(negedge cpu_clk);
      k++;
    end
    chk("mid_reset_writes", exp_wr.size(), 32'h0);
    repeat (3) @(negedge cpu_clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("mid_reset");
    uq.delete();
    exp_wr.delete();
    model_err = 0;
    @(negedge cpu_clk);
    rst_n = 1'b1;
    repeat (30) @(negedge cpu_clk);
    #1;
    chk("post_reset_idle", {31'h0, busy}, 32'h0);
    d = '{8'h99};
    put_load(16'h2002, 1, d, 8'h00);
    wait_idle("post_reset_load", 1000);

    for (int f = 0; f < 30; f++) begin
      r = $urandom_range(0, 9);
      if (r < 6) begin
        n = (f == 10) ? 256 : $urandom_range(1, 8);
        d.delete();
        for (int i = 0; i < n; i++) d.push_back(8'($urandom));
        a = 16'($urandom);
        bad = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
        put_load(a, n, d, bad);
      end else if (r < 8) begin
        put_go(16'($urandom));
      end else begin
        b = 8'($urandom);
        if (b == 8'h55 || b == 8'h47) b = 8'h00;
        uq.push_back(b);
      end
      wait_idle("random", 4000);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
